// File: rtl/rv_go_fetch_unit.sv
// Instruction-fetch front end: issues PC-ordered requests to instruction memory,
// queues returned words with their PCs and hands them to decode; EX redirects flush.
module rv_go_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         imem_req_valid,
  output logic [XLEN-1:0]              imem_req_addr,
  input  logic                         imem_req_ready,
  input  logic                         imem_rsp_valid,
  input  logic [31:0]                  imem_rsp_data,
  output logic                         out_valid,
  output logic [31:0]                  out_instr,
  output logic [XLEN-1:0]              out_pc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  ent_pc    [DEPTH];
  logic [31:0]      ent_instr [DEPTH];
  logic [DEPTH-1:0] ent_filled;
  logic [PW-1:0]    tail_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]    occ_q, pending_cnt, drop_cnt;
  logic [CW:0]      credit_used;
  logic             req_accept, rsp_fill, rsp_drop, deq;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

  // Credits and handshakes come only from registered state plus the redirect/reset inputs.
  always_comb begin
    credit_used    = (CW+1)'(occ_q) + (CW+1)'(drop_cnt);
    imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    out_valid      = ent_filled[head_ptr] && !redirect_valid;
    req_accept     = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid && (drop_cnt == '0);
    deq            = out_valid && out_ready;
  end

  assign imem_req_addr = fetch_pc;
  assign out_instr     = ent_instr[head_ptr];
  assign out_pc        = ent_pc[head_ptr];
  assign occupancy     = occ_q;

  // Control state: pointers, counters, filled flags and the fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occ_q       <= '0;
      pending_cnt <= '0;
      drop_cnt    <= '0;
      ent_filled  <= '0;
    end else if (redirect_valid) begin
      // Every outstanding request becomes stale; a response arriving now is one of them.
      fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      tail_ptr    <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occ_q       <= '0;
      pending_cnt <= '0;
      drop_cnt    <= drop_cnt + pending_cnt - CW'(imem_rsp_valid);
      ent_filled  <= '0;
    end else begin
      if (req_accept) begin
        tail_ptr <= tail_ptr + PW'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_fill) begin
        ent_filled[fill_ptr] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (deq) begin
        ent_filled[head_ptr] <= 1'b0;
        head_ptr             <= head_ptr + PW'(1);
      end
      occ_q       <= occ_q + CW'(req_accept) - CW'(deq);
      pending_cnt <= pending_cnt + CW'(req_accept) - CW'(rsp_fill);
    end
  end

  // Entry payload; validity is tracked by ent_filled so no reset is needed here.
  always_ff @(posedge clk) begin
    if (req_accept) begin
      ent_pc[tail_ptr] <= fetch_pc;
    end
    if (rsp_fill && !redirect_valid && !rst) begin
      ent_instr[fill_ptr] <= imem_rsp_data;
    end
  end

endmodule
